// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA pixel fetch, a fill engine and a CPU port.
// Priority per cycle: VGA fetch > fill > CPU; fetch data lands on pix_data two cycles after its address.
module vga_fb_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17,
  parameter int FB_W   = 320,
  parameter int FB_H   = 240
) (
  input  logic              CLK25,
  input  logic              reset,
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  output logic [DATA_W-1:0] pix_data,
  output logic              vblank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   fill_addr_q;
  logic [DATA_W-1:0]   fill_color_q;
  logic [DATA_W-1:0]   pix_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                fetch_q;
  logic                cpu_rd_q;
  logic                cpu_oor_q;
  logic                cpu_rvalid_q;
  logic                fill_done_q;
  logic                vblank_q;

  logic [9:0]          next_line;
  logic [9:0]          row_line;
  logic                fetch_act;
  logic                fetch_pre;
  logic                vga_slot;
  logic                fill_wr;
  logic                cpu_oor;
  logic [ADDR_W-1:0]   fetch_col;
  logic [ADDR_W-1:0]   fetch_addr;

  assign next_line = (py == 10'd524) ? 10'd0 : py + 10'd1;

  // Active fetch runs one framebuffer column ahead; px==798 prefetches column 0 of the next line.
  assign fetch_act = !px[0] && (px <= 10'd636) && (py <= 10'd479);
  assign fetch_pre = (px == 10'd798) && (next_line < 10'd480);
  assign vga_slot  = fetch_act || fetch_pre;

  assign row_line   = fetch_pre ? next_line : py;
  assign fetch_col  = fetch_pre ? '0 : ADDR_W'(px >> 1) + ADDR_W'(1);
  assign fetch_addr = ADDR_W'(row_line >> 1) * ADDR_W'(FB_W) + fetch_col;

  assign fill_wr = !vga_slot && (state_q == FILL);
  assign cpu_gnt = !vga_slot && (state_q == IDLE) && cpu_req && !fill_start;
  assign cpu_oor = (cpu_addr >= FB_WORDS);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (vga_slot) begin
      mem_addr = fetch_addr;
    end else if (fill_wr) begin
      mem_addr  = fill_addr_q;
      mem_we    = 1'b1;
      mem_wdata = fill_color_q;
    end else if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we && !cpu_oor;
      mem_wdata = cpu_wdata;
    end
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge CLK25 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fill_addr_q  <= '0;
      fill_color_q <= '0;
      pix_q        <= '0;
      cpu_rdata_q  <= '0;
      fetch_q      <= 1'b0;
      cpu_rd_q     <= 1'b0;
      cpu_oor_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      fill_done_q  <= 1'b0;
      vblank_q     <= 1'b0;
    end else begin
      fetch_q      <= vga_slot;
      cpu_rd_q     <= cpu_gnt && !cpu_we;
      cpu_oor_q    <= cpu_oor;
      cpu_rvalid_q <= cpu_rd_q;
      vblank_q     <= (py >= 10'd480);
      fill_done_q  <= 1'b0;
      if (fetch_q) pix_q <= mem_rdata;
      if (cpu_rd_q) cpu_rdata_q <= cpu_oor_q ? '0 : mem_rdata;
      case (state_q)
        IDLE: begin
          if (fill_start) begin
            state_q      <= FILL;
            fill_color_q <= fill_color;
            fill_addr_q  <= '0;
          end
        end
        FILL: begin
          if (fill_wr) begin
            if (fill_addr_q == FB_LAST) begin
              state_q     <= IDLE;
              fill_done_q <= 1'b1;
            end else begin
              fill_addr_q <= fill_addr_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_data   = pix_q;
  assign vblank     = vblank_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign fill_busy  = (state_q == FILL);
  assign fill_done  = fill_done_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench: stimulus pushes expected pixels / read data, a negedge monitor pops and compares.
module tb_vga_fb_arbiter;

  logic        CLK25 = 1'b0;
  logic        reset;
  logic [9:0]  px, py;
  logic [7:0]  pix_data;
  logic        vblank;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        cpu_req, cpu_we;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        fill_start;
  logic [7:0]  fill_color;
  logic        fill_busy, fill_done;

  always #5 CLK25 = ~CLK25;

  vga_fb_arbiter dut (
    .CLK25(CLK25), .reset(reset), .px(px), .py(py), .pix_data(pix_data), .vblank(vblank),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done)
  );

  // External synchronous RAM model, full 17-bit space so suppressed writes are observable.
  logic [7:0] ram [0:131071];
  logic       preload_go = 1'b0;
  logic [1:0] preload_mode = 2'd0;

  function automatic logic [7:0] pl_val(input logic [1:0] m, input int i);
    if (i >= 76800) return 8'h11;
    if (m == 2'd0) return 8'(i % 320);
    return 8'((i % 320) ^ (i / 320));
  endfunction

  always @(posedge CLK25) begin
    if (preload_go) begin
      for (int i = 0; i < 131072; i++) ram[i] <= pl_val(preload_mode, i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int         checks = 0;
  int         errors = 0;
  logic       pix_chk = 1'b0;
  int         pat = 0;
  logic [7:0] pix_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int m, input int x, input int y);
    int c, r, a;
    c = x >> 1;
    r = y >> 1;
    a = r * 320 + c;
    if (m == 0) return 8'(c);
    if (m == 1) return 8'(c ^ r);
    return (a < 1000) ? 8'h5A : 8'h3C;
  endfunction

  always @(negedge CLK25) begin
    if (pix_chk && px < 10'd640 && py < 10'd480) begin
      if (pix_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix_underflow x%0d y%0d: got %0h, expected none", px, py, pix_data);
      end else begin
        mon_e = pix_q.pop_front();
        chk($sformatf("pix x%0d y%0d", px, py), pix_data, mon_e);
      end
    end
    if (cpu_rvalid) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got %0h, expected no read", cpu_rdata);
      end else begin
        mon_e = rd_q.pop_front();
        chk("cpu_rdata", cpu_rdata, mon_e);
      end
    end
  end

  task automatic push_pix();
    if (pix_chk && px < 10'd640 && py < 10'd480) pix_q.push_back(exp_pix(pat, px, py));
  endtask

  task automatic step();
    @(posedge CLK25); #1;
    if (px == 10'd799) begin
      px = 10'd0;
      py = (py == 10'd524) ? 10'd0 : py + 10'd1;
    end else begin
      px = px + 10'd1;
    end
    push_pix();
  endtask

  task automatic go_to(input int x, input int y);
    @(posedge CLK25); #1;
    px = 10'(x);
    py = 10'(y);
    push_pix();
  endtask

  task automatic wait_gnt(output int waited);
    waited = -1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK25);
      if (cpu_gnt) begin
        waited = k;
        break;
      end
      step();
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, bad, busy_cycles, gnt_busy, done_cnt, gnt_seen, post;
    logic gnt_prev;
    reset = 1'b1; px = 10'd0; py = 10'd500;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    fill_start = 1'b0; fill_color = '0;

    preload_mode = 2'd0; preload_go = 1'b1;
    @(posedge CLK25); #1; preload_go = 1'b0;
    @(negedge CLK25);
    chk("rst_pix", pix_data, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_vblank", vblank, 0);
    chk("rst_we", mem_we, 0);
    @(posedge CLK25); #1; reset = 1'b0;

    // Column pattern, lines 0..3 after the column-0 prefetch of line 524.
    pat = 0;
    go_to(790, 524);
    pix_chk = 1'b1;
    while (!(py == 10'd3 && px == 10'd799)) step();
    pix_chk = 1'b0;

    // Row-sensitive pattern over the bottom lines and the vblank edge.
    preload_mode = 2'd1; preload_go = 1'b1;
    step();
    preload_go = 1'b0;
    pat = 1;
    go_to(790, 477);
    pix_chk = 1'b1;
    while (!(py == 10'd480 && px == 10'd700)) begin
      step();
      if (py == 10'd479 && px == 10'd700) begin @(negedge CLK25); chk("vblank_479", vblank, 0); end
      if (py == 10'd480 && px == 10'd0)   begin @(negedge CLK25); chk("vblank_480_px0", vblank, 0); end
      if (py == 10'd480 && px == 10'd1)   begin @(negedge CLK25); chk("vblank_480_px1", vblank, 1); end
    end
    pix_chk = 1'b0;
    @(negedge CLK25);
    chk("pix_hold_vblank", pix_data, 8'hD0);

    // CPU write held from px=10: VGA slot at 10, grant at 11.
    go_to(5, 0);
    while (px != 10'd10) step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd100; cpu_wdata = 8'hA5;
    @(negedge CLK25);
    chk("gnt_px10", cpu_gnt, 0);
    step();
    @(negedge CLK25);
    chk("gnt_px11", cpu_gnt, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 100);
    step();
    cpu_req = 1'b0;
    @(negedge CLK25);
    chk("gnt_px12", cpu_gnt, 0);
    chk("ram100", ram[100], 8'hA5);

    // Out-of-range write is granted but suppressed; read returns zero.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd76800; cpu_wdata = 8'hFF;
    @(negedge CLK25);
    chk("oor_gnt_vga", cpu_gnt, 0);
    step();
    @(negedge CLK25);
    chk("oor_gnt", cpu_gnt, 1);
    chk("oor_we", mem_we, 0);
    step();
    cpu_req = 1'b0;
    @(negedge CLK25);
    chk("oor_ram", ram[76800], 8'h11);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd76800;
    rd_q.push_back(8'h00);
    wait_gnt(w);
    chk("oor_rd_wait", w, 1);
    step(); cpu_req = 1'b0;
    step(); step();

    // Read-back of addr 100: rvalid only at t+2.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd100;
    rd_q.push_back(8'hA5);
    wait_gnt(w);
    chk("rd_wait", w, 1);
    step(); cpu_req = 1'b0;
    @(negedge CLK25); chk("rvalid_t1", cpu_rvalid, 0);
    step();
    @(negedge CLK25); chk("rvalid_t2", cpu_rvalid, 1);
    step();
    @(negedge CLK25); chk("rvalid_t3", cpu_rvalid, 0);
    chk("rdata_hold", cpu_rdata, 8'hA5);

    // Fill in vblank with a competing CPU write; the CPU must wait for the whole fill.
    go_to(0, 490);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd5; cpu_wdata = 8'h77;
    fill_color = 8'h3C; fill_start = 1'b1;
    @(negedge CLK25);
    chk("fill_vs_cpu_gnt", cpu_gnt, 0);
    chk("busy_before", fill_busy, 0);
    step();
    fill_start = 1'b0; fill_color = 8'h00;
    @(negedge CLK25);
    chk("busy_next", fill_busy, 1);
    busy_cycles = 1; gnt_busy = 0; done_cnt = 0; gnt_seen = 0; post = -1; gnt_prev = 1'b0;
    for (int k = 0; k < 80000; k++) begin
      step();
      if (py == 10'd520) py = 10'd490;
      if (gnt_prev) cpu_req = 1'b0;
      @(negedge CLK25);
      if (fill_busy) busy_cycles++;
      if (fill_busy && cpu_gnt) gnt_busy++;
      if (fill_done) done_cnt++;
      if (cpu_gnt) gnt_seen++;
      gnt_prev = cpu_gnt;
      if (done_cnt > 0) post++;
      if (post == 8) break;
    end
    cpu_req = 1'b0;
    chk("fill_done_pulses", done_cnt, 1);
    chk("fill_busy_cycles", busy_cycles, 76800);
    chk("gnt_while_busy", gnt_busy, 0);
    chk("cpu_gnt_after_fill", gnt_seen, 1);
    chk("busy_after", fill_busy, 0);
    bad = 0;
    for (int i = 0; i < 76800; i++) begin
      if (i == 5) begin
        if (ram[i] != 8'h77) bad++;
      end else if (ram[i] != 8'h3C) begin
        bad++;
      end
    end
    chk("fill_ram_bad_words", bad, 0);
    chk("fill_bound", ram[76800], 8'h11);

    // Reset after 1000 fill writes.
    fill_color = 8'h5A; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (py == 10'd520) py = 10'd490;
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", fill_busy, 0);
    chk("mid_rst_rvalid", cpu_rvalid, 0);
    chk("mid_rst_pix", pix_data, 0);
    chk("mid_rst_rdata", cpu_rdata, 0);
    chk("mid_rst_we", mem_we, 0);
    step();
    @(negedge CLK25);
    chk("mid_rst_we_held", mem_we, 0);
    chk("ram999", ram[999], 8'h5A);
    chk("ram1000", ram[1000], 8'h3C);
    @(posedge CLK25); #1; reset = 1'b0;

    // Fetch resumes: row 3 straddles the partial-fill boundary at address 1000.
    pat = 2;
    go_to(790, 5);
    pix_chk = 1'b1;
    while (!(py == 10'd7 && px == 10'd799)) step();
    pix_chk = 1'b0;
    step();

    chk("rd_queue_left", rd_q.size(), 0);
    chk("pix_queue_left", pix_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
